// File: rtl/io_arb_pkg.sv
// Shared definitions for the simple-I/O write arbiter: register selects,
// FSM state encoding and the select-to-write-enable decode.
package io_arb_pkg;

    localparam logic [1:0] SEL_LED_DISP  = 2'd0;
    localparam logic [1:0] SEL_GPIO_DATA = 2'd1;
    localparam logic [1:0] SEL_GPIO_DIR  = 2'd2;
    localparam logic [1:0] SEL_IRQ       = 2'd3;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bank write enables are MSB-first: sel 0 drives bit 3, sel 3 drives bit 0.
    function automatic logic [3:0] sel_to_ce(input logic [1:0] sel);
        return 4'b1000 >> sel;
    endfunction

endpackage

// File: rtl/io_write_arbiter_ack_timer.sv
// Cycle counter for an outstanding bank write; flags expiry on the last
// permitted cycle so the FSM can close the write with an error.
module ack_timer #(
    parameter int C_ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    import io_arb_pkg::*;

    localparam logic [TIMER_W-1:0] LP_LAST = TIMER_W'(C_ACK_TIMEOUT - 1);

    logic [TIMER_W-1:0] r_count;

    // NOTE: reset is sampled on the clock edge, so it lives inside always_ff
    // and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LP_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == LP_LAST);

endmodule

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter sequencing single register writes from two requesters
// onto the simple-I/O bank, with acknowledge timeout and error counting.
module io_write_arbiter
    import io_arb_pkg::*;
#(
    parameter int C_SLV_DWIDTH  = 32,
    parameter int C_ACK_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic [1:0]              req0_sel,
    input  logic [C_SLV_DWIDTH-1:0] req0_data,
    output logic                    req0_ready,
    output logic                    req0_err,
    input  logic                    req1_valid,
    input  logic [1:0]              req1_sel,
    input  logic [C_SLV_DWIDTH-1:0] req1_data,
    output logic                    req1_ready,
    output logic                    req1_err,
    output logic [3:0]              wr_ce,
    output logic [3:0]              wr_be,
    output logic [C_SLV_DWIDTH-1:0] wr_data,
    input  logic                    wr_ack,
    output logic                    owner,
    output logic [7:0]              err_cnt
);

    state_t                  r_state;
    logic                    r_owner;
    logic [3:0]              r_wr_ce;
    logic [3:0]              r_wr_be;
    logic [C_SLV_DWIDTH-1:0] r_wr_data;
    logic                    r_req0_ready;
    logic                    r_req1_ready;
    logic                    r_req0_err;
    logic                    r_req1_err;
    logic [7:0]              r_err_cnt;

    logic                    w_any_valid;
    logic                    w_grant;
    logic [1:0]              w_sel;
    logic [C_SLV_DWIDTH-1:0] w_data;
    logic                    w_expired;
    logic                    w_timeout;
    logic                    w_finish;

    // On a tie the requester that did not win last time goes next.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant     = (req0_valid && req1_valid) ? ~r_owner : req1_valid;
    assign w_sel       = w_grant ? req1_sel  : req0_sel;
    assign w_data      = w_grant ? req1_data : req0_data;

    // An acknowledge on the expiry cycle wins over the timeout.
    assign w_finish  = wr_ack || w_expired;
    assign w_timeout = !wr_ack && w_expired;

    ack_timer #(
        .C_ACK_TIMEOUT(C_ACK_TIMEOUT)
    ) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state == ST_IDLE),
        .i_enable (r_state == ST_ISSUE),
        .o_expired(w_expired)
    );

    // NOTE: every register here uses non-blocking assignment so all updates
    // see the pre-edge values and ordering inside the block does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b1;
            r_wr_ce      <= '0;
            r_wr_be      <= '0;
            r_wr_data    <= '0;
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_req0_err   <= 1'b0;
            r_req1_err   <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_req0_err   <= 1'b0;
            r_req1_err   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_owner   <= w_grant;
                        r_wr_ce   <= sel_to_ce(w_sel);
                        r_wr_be   <= 4'hF;
                        r_wr_data <= w_data;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_finish) begin
                        r_wr_ce      <= '0;
                        r_wr_be      <= '0;
                        r_req0_ready <= ~r_owner;
                        r_req1_ready <= r_owner;
                        r_req0_err   <= w_timeout && !r_owner;
                        r_req1_err   <= w_timeout && r_owner;
                        if (w_timeout && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = r_req0_ready;
    assign req1_ready = r_req1_ready;
    assign req0_err   = r_req0_err;
    assign req1_err   = r_req1_err;
    assign wr_ce      = r_wr_ce;
    assign wr_be      = r_wr_be;
    assign wr_data    = r_wr_data;
    assign owner      = r_owner;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed self-checking bench for io_write_arbiter; outputs are sampled on
// the falling edge, inputs are driven on the falling edge.
module tb_io_write_arbiter;
    import io_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_sel, req1_sel;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, req0_err, req1_err;
    logic [3:0]  wr_ce, wr_be;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        owner;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    io_write_arbiter #(
        .C_SLV_DWIDTH (32),
        .C_ACK_TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_sel  (req0_sel),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req0_err  (req0_err),
        .req1_valid(req1_valid),
        .req1_sel  (req1_sel),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .req1_err  (req1_err),
        .wr_ce     (wr_ce),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .owner     (owner),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req0_sel = 2'd0; req0_data = '0;
        req1_valid = 1'b0; req1_sel = 2'd0; req1_data = '0;
        wr_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++; if (wr_ce !== 4'b0000) begin n_errors++; $display("FAIL reset_ce: got %b exp 0000", wr_ce); end
        n_checks++; if (wr_be !== 4'b0000) begin n_errors++; $display("FAIL reset_be: got %b exp 0000", wr_be); end
        n_checks++; if (wr_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h exp 0", wr_data); end
        n_checks++; if ({req0_ready, req1_ready, req0_err, req1_err} !== 4'b0000) begin n_errors++; $display("FAIL reset_handshake: got %b exp 0000", {req0_ready, req1_ready, req0_err, req1_err}); end
        n_checks++; if (owner !== 1'b1) begin n_errors++; $display("FAIL reset_owner: got %b exp 1", owner); end
        n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_err_cnt: got %0d exp 0", err_cnt); end
    endtask

    task automatic test_single_write();
        wr_ack = 1'b1;
        req0_valid = 1'b1; req0_sel = SEL_LED_DISP; req0_data = 32'h0000_01A5;
        tick();
        n_checks++; if (wr_ce !== 4'b1000) begin n_errors++; $display("FAIL single_ce: got %b exp 1000", wr_ce); end
        n_checks++; if (wr_be !== 4'hF) begin n_errors++; $display("FAIL single_be: got %h exp f", wr_be); end
        n_checks++; if (wr_data !== 32'h0000_01A5) begin n_errors++; $display("FAIL single_data: got %h exp 000001a5", wr_data); end
        n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL single_early_ready: got %b exp 0", req0_ready); end
        tick();
        n_checks++; if (wr_ce !== 4'b0000) begin n_errors++; $display("FAIL single_ce_off: got %b exp 0000", wr_ce); end
        n_checks++; if ({req0_ready, req0_err} !== 2'b10) begin n_errors++; $display("FAIL single_ready: got %b exp 10", {req0_ready, req0_err}); end
        req0_valid = 1'b0;
        tick();
        n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL single_ready_pulse: got %b exp 0", req0_ready); end
        n_checks++; if (owner !== 1'b0) begin n_errors++; $display("FAIL single_owner: got %b exp 0", owner); end
        n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL single_err_cnt: got %0d exp 0", err_cnt); end
        wr_ack = 1'b0;
    endtask

    task automatic test_tie_alternation();
        logic exp_w;
        rst = 1'b1; tick(); rst = 1'b0;
        wr_ack = 1'b1;
        req0_valid = 1'b1; req0_sel = SEL_GPIO_DATA; req0_data = 32'h1111_0000;
        req1_valid = 1'b1; req1_sel = SEL_GPIO_DIR;  req1_data = 32'h2222_0001;
        for (int i = 0; i < 4; i++) begin
            exp_w = 1'(i % 2);
            tick();
            n_checks++; if (owner !== exp_w) begin n_errors++; $display("FAIL tie_owner[%0d]: got %b exp %b", i, owner, exp_w); end
            n_checks++; if (wr_ce !== (exp_w ? 4'b0010 : 4'b0100)) begin n_errors++; $display("FAIL tie_ce[%0d]: got %b exp %b", i, wr_ce, exp_w ? 4'b0010 : 4'b0100); end
            n_checks++; if (wr_data !== (exp_w ? 32'h2222_0001 : 32'h1111_0000)) begin n_errors++; $display("FAIL tie_data[%0d]: got %h", i, wr_data); end
            tick();
            n_checks++; if ({req0_ready, req1_ready} !== (exp_w ? 2'b01 : 2'b10)) begin n_errors++; $display("FAIL tie_ready[%0d]: got %b exp %b", i, {req0_ready, req1_ready}, exp_w ? 2'b01 : 2'b10); end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wr_ack = 1'b0;
        tick();
        n_checks++; if (wr_ce !== 4'b0000) begin n_errors++; $display("FAIL tie_idle_ce: got %b exp 0000", wr_ce); end
    endtask

    task automatic test_timeout();
        int  ce_cycles = 0;
        logic seen = 1'b0;
        logic got_err = 1'b0;
        logic bad_ce = 1'b0;
        logic other = 1'b0;
        req1_valid = 1'b1; req1_sel = SEL_IRQ; req1_data = 32'h0000_00F3;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (wr_ce != 4'b0000) begin
                ce_cycles++;
                if (wr_ce !== 4'b0001) bad_ce = 1'b1;
            end
            if (req0_ready) other = 1'b1;
            if (req1_ready) begin
                seen = 1'b1;
                got_err = req1_err;
            end
        end
        n_checks++; if (!seen) begin n_errors++; $display("FAIL timeout_ready: got none within 40 cycles exp pulse"); end
        n_checks++; if (ce_cycles != 16) begin n_errors++; $display("FAIL timeout_ce_cycles: got %0d exp 16", ce_cycles); end
        n_checks++; if (bad_ce) begin n_errors++; $display("FAIL timeout_ce_value: got non-0001 enable exp 0001"); end
        n_checks++; if (got_err !== 1'b1) begin n_errors++; $display("FAIL timeout_err: got %b exp 1", got_err); end
        n_checks++; if (other) begin n_errors++; $display("FAIL timeout_req0_ready: got 1 exp 0"); end
        n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL timeout_err_cnt: got %0d exp 1", err_cnt); end
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_delayed_ack();
        req0_valid = 1'b1; req0_sel = SEL_GPIO_DATA; req0_data = 32'hCAFE_0001;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++; if (wr_ce !== 4'b0100) begin n_errors++; $display("FAIL delay_ce[%0d]: got %b exp 0100", c, wr_ce); end
            n_checks++; if (wr_data !== 32'hCAFE_0001) begin n_errors++; $display("FAIL delay_data[%0d]: got %h exp cafe0001", c, wr_data); end
            if (c == 2) begin
                req0_valid = 1'b0; req0_sel = SEL_IRQ; req0_data = 32'hDEAD_BEEF;
            end
            if (c == 6) wr_ack = 1'b1;
        end
        tick();
        wr_ack = 1'b0;
        n_checks++; if (wr_ce !== 4'b0000) begin n_errors++; $display("FAIL delay_ce_off: got %b exp 0000", wr_ce); end
        n_checks++; if ({req0_ready, req0_err} !== 2'b10) begin n_errors++; $display("FAIL delay_ready: got %b exp 10", {req0_ready, req0_err}); end
        n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL delay_err_cnt: got %0d exp 1", err_cnt); end
        tick();
        n_checks++; if (wr_ce !== 4'b0000) begin n_errors++; $display("FAIL delay_no_reissue: got %b exp 0000", wr_ce); end
    endtask

    task automatic test_reset_mid_issue();
        req1_valid = 1'b1; req1_sel = SEL_GPIO_DIR; req1_data = 32'h0BAD_0BAD;
        tick();
        n_checks++; if (wr_ce !== 4'b0010) begin n_errors++; $display("FAIL rstmid_ce: got %b exp 0010", wr_ce); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (wr_ce !== 4'b0000) begin n_errors++; $display("FAIL rstmid_ce_off: got %b exp 0000", wr_ce); end
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_errors++; $display("FAIL rstmid_ready: got %b exp 00", {req0_ready, req1_ready}); end
        n_checks++; if (owner !== 1'b1) begin n_errors++; $display("FAIL rstmid_owner: got %b exp 1", owner); end
        req0_valid = 1'b1; req0_sel = SEL_LED_DISP; req0_data = 32'h0000_0077;
        tick();
        n_checks++; if (owner !== 1'b0) begin n_errors++; $display("FAIL rstmid_tie_owner: got %b exp 0", owner); end
        n_checks++; if (wr_ce !== 4'b1000) begin n_errors++; $display("FAIL rstmid_tie_ce: got %b exp 1000", wr_ce); end
        n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_stale_ready: got %b exp 0", req1_ready); end
        wr_ack = 1'b1;
        tick();
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_errors++; $display("FAIL rstmid_done: got %b exp 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wr_ack = 1'b0;
        tick();
    endtask

    task automatic test_err_saturation();
        int   pulses = 0;
        int   errs = 0;
        logic hung = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_sel = SEL_LED_DISP; req0_data = 32'h5A5A_5A5A;
        for (int w = 0; w < 260 && !hung; w++) begin
            logic seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                tick();
                if (req0_ready) begin
                    seen = 1'b1;
                    pulses++;
                    if (req0_err) errs++;
                end
            end
            if (!seen) hung = 1'b1;
            if (w == 253) begin
                n_checks++; if (err_cnt !== 8'd254) begin n_errors++; $display("FAIL sat_err_cnt_254: got %0d exp 254", err_cnt); end
            end
            if (w == 254) begin
                n_checks++; if (err_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_err_cnt_255: got %0d exp 255", err_cnt); end
            end
            if (w == 259) req0_valid = 1'b0;
        end
        n_checks++; if (hung) begin n_errors++; $display("FAIL sat_ready: got no pulse within 40 cycles exp pulse"); end
        n_checks++; if (pulses != 260) begin n_errors++; $display("FAIL sat_pulses: got %0d exp 260", pulses); end
        n_checks++; if (errs != 260) begin n_errors++; $display("FAIL sat_errs: got %0d exp 260", errs); end
        n_checks++; if (err_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_err_cnt_final: got %0d exp 255", err_cnt); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_tie_alternation();
        test_timeout();
        test_delayed_ack();
        test_reset_mid_issue();
        test_err_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/io_write_arbiter.md
# io_write_arbiter

Round-robin write arbiter and sequencer that shares the simple-I/O register bank (LED/DISP, GPIO data, GPIO direction, IE/IF) between two requesters, e.g. the game engine and the CPU. Each requester posts one 32-bit register write over a valid/ready handshake. The arbiter presents one write at a time to the bank as a held one-hot write-enable with full byte enables, and waits for the bank acknowledge. A missing acknowledge ends the write with an error on a programmable timeout.

## Interface
Parameters:
- C_SLV_DWIDTH, 32, data width; must be 32.
- C_ACK_TIMEOUT, 16, max cycles `wr_ce` stays asserted without `wr_ack`; range 2..255.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_valid  in  1  requester 0 write pending.
- req0_sel  in  2  target register select (0 LED/DISP, 1 GPIO data, 2 GPIO dir, 3 IE/IF).
- req0_data  in  32  write data.
- req0_ready  out  1  one-cycle pulse: requester 0 write completed.
- req0_err  out  1  one-cycle pulse with `req0_ready`: completed by timeout.
- req1_valid, req1_sel, req1_data, req1_ready, req1_err: same as requester 0, for requester 1.
- wr_ce  out  4  one-hot bank write enable; bit 3 = sel 0 … bit 0 = sel 3.
- wr_be  out  4  byte enables; 4'hF while `wr_ce` is non-zero, else 0.
- wr_data  out  32  latched write data.
- wr_ack  in  1  bank write acknowledge.
- owner  out  1  index of the last granted requester.
- err_cnt  out  8  saturating timeout count.

## Operation
- FSM has three states:
  - IDLE: arbitrate. If any valid is high, latch the winner's sel/data, set `owner` = winner, go to ISSUE.
  - ISSUE: `wr_ce` = 4'b1000 >> sel, `wr_be` = 4'hF, `wr_data` = latched data. If `wr_ack` → DONE (ok). Else if the timer reaches C_ACK_TIMEOUT-1 → DONE (error).
  - DONE: `wr_ce` = 0. Pulse `reqN_ready` for the winner; pulse `reqN_err` too if error. Increment `err_cnt` on error, saturating at 255. Go to IDLE.
- Arbitration:
  - A single requester wins immediately.
  - Simultaneous requests go to the requester that is not `owner` (strict alternation).
- Requesters hold valid and payload until their ready pulse. Payload changes or valid drops after grant are ignored; the latched write completes and ready still pulses.
- `wr_ack` in IDLE or DONE is ignored.
- `wr_ack` in the same cycle as timer expiry counts as success.
- A requester whose valid is still high after its ready pulse issues a new write. It wins IDLE only if the other requester is idle.
- Reset values: state IDLE; `wr_ce`, `wr_be`, `wr_data` = 0; all ready/err = 0; `owner` = 1, so requester 0 wins the first tie; `err_cnt` = 0; timer = 0.
- `rst` mid-ISSUE deasserts `wr_ce` next edge; no ready pulse is issued for the aborted write.

## Timing
- All outputs are registered.
- Edge k samples valid in IDLE → `wr_ce` asserted from cycle k+1.
- `wr_ack` sampled at edge m in ISSUE → `wr_ce` low and ready high in cycle m+1 → next IDLE cycle m+2. With immediate ack, latency is 3 cycles valid-to-ready-pulse, throughput one write per 3 cycles.
- Timeout: `wr_ce` asserted exactly C_ACK_TIMEOUT cycles, then ready+err pulse for 1 cycle.
- The timer clears on entry to ISSUE and counts each ISSUE cycle; width 8 bits.

## Structure
- Shared package `io_arb_pkg`:
  - select constants SEL_LED_DISP=0, SEL_GPIO_DATA=1, SEL_GPIO_DIR=2, SEL_IRQ=3;
  - FSM state enum (IDLE, ISSUE, DONE);
  - function sel→one-hot `wr_ce`.
- One natural sub-module: `ack_timer` (clear, enable, expiry flag at C_ACK_TIMEOUT-1).
- Arbitration and FSM stay in the top.

## Test plan
- Reset, then req0 valid sel=0 data=32'h0000_01A5, `wr_ack` tied high → `wr_ce`=4'b1000 and `wr_data`=32'h0000_01A5 for 1 cycle; `req0_ready` pulses 3 cycles after valid; `err_cnt`=0.
- req0 and req1 valid in the same cycle, ack immediate → req0 served first, then req1; continuous both-valid alternates 0,1,0,1 with `owner` toggling.
- req1 sel=3, `wr_ack` never asserted, C_ACK_TIMEOUT=16 → `wr_ce`=4'b0001 for exactly 16 cycles; `req1_ready` and `req1_err` pulse together; `err_cnt`=1.
- `wr_ack` delayed 5 cycles, req0 drops valid and changes data mid-ISSUE → latched data stays on `wr_data`; `wr_ce` is held 6 cycles; `req0_ready` pulses, no err.
- `rst` asserted during ISSUE → next cycle `wr_ce`=0 and no ready pulse; after release, a tie goes to req0.
- 260 consecutive timeouts → `err_cnt` saturates at 255.
